// File: rtl/wb_host_bridge_if.sv
// Wishbone B4 pipelined bus between the host bridge (master) and a register bank (slave).
// Signal names follow the master's view of direction.
interface wb_host_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic [31:0]           wb_dat_o;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;
  logic [31:0]           wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );
endinterface

// File: rtl/wb_host_bridge.sv
// Single-outstanding Wishbone pipelined master: host request/done to one bus cycle,
// with bounded retry on rty and a per-attempt cycle timeout.
module wb_host_bridge #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_adr_i,
  input  logic [3:0]            host_sel_i,
  input  logic [31:0]           host_dat_i,
  output logic                  host_ready_o,
  output logic                  host_done_o,
  output logic                  host_err_o,
  output logic [31:0]           host_dat_o,
  wb_host_bridge_if.master      wb
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStrobe = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;

  localparam logic [7:0] TmoLast  = 8'(TIMEOUT - 1);
  localparam logic [2:0] RetryMax = 3'(MAX_RETRY);

  logic [1:0]            state_q, state_d;
  logic                  gap_q, gap_d;
  logic [2:0]            retry_q, retry_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           wdat_q, wdat_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [31:0]           rdat_q, rdat_d;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    err_d   = err_q;
    rdat_d  = rdat_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // gap_q marks the single dead cycle between a retried attempt and its re-issue
        if (gap_q) begin
          gap_d   = 1'b0;
          tmo_d   = '0;
          state_d = StStrobe;
        end else if (host_req_i) begin
          we_d    = host_we_i;
          adr_d   = host_adr_i;
          sel_d   = host_sel_i;
          wdat_d  = host_dat_i;
          retry_d = '0;
          tmo_d   = '0;
          state_d = StStrobe;
        end
      end
      StStrobe, StWait: begin
        tmo_d = tmo_q + 8'd1;
        if (wb.wb_err_i) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (wb.wb_ack_i) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b0;
          if (!we_q) rdat_d = wb.wb_dat_i;
        end else if (wb.wb_rty_i) begin
          state_d = StIdle;
          if (retry_q < RetryMax) begin
            retry_d = retry_q + 3'd1;
            gap_d   = 1'b1;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end else if (tmo_q == TmoLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (state_q == StStrobe && !wb.wb_stall_i) begin
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      gap_q   <= 1'b0;
      retry_q <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  assign wb.wb_cyc_o   = (state_q != StIdle);
  assign wb.wb_stb_o   = (state_q == StStrobe);
  assign wb.wb_we_o    = we_q;
  assign wb.wb_adr_o   = adr_q;
  assign wb.wb_sel_o   = sel_q;
  assign wb.wb_dat_o   = wdat_q;
  assign host_ready_o  = (state_q == StIdle) && !gap_q;
  assign host_done_o   = done_q;
  assign host_err_o    = err_q;
  assign host_dat_o    = rdat_q;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Randomized bench for wb_host_bridge: a cycle-indexed timeline of expected outputs is built
// from transaction plans, then replayed against the DUT with per-cycle comparison.
module tb_wb_host_bridge;
  localparam int unsigned AW   = 4;
  localparam int unsigned TMO  = 8;
  localparam int unsigned MR   = 2;
  localparam int          NCYC = 4096;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_NONE = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_req, host_we;
  logic [AW-1:0] host_adr;
  logic [3:0]    host_sel;
  logic [31:0]   host_wdat;
  logic          host_ready, host_done, host_err;
  logic [31:0]   host_rdat;

  always #5 clk = ~clk;

  wb_host_bridge_if #(.ADDR_WIDTH(AW)) wb ();

  wb_host_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .host_req_i  (host_req),
    .host_we_i   (host_we),
    .host_adr_i  (host_adr),
    .host_sel_i  (host_sel),
    .host_dat_i  (host_wdat),
    .host_ready_o(host_ready),
    .host_done_o (host_done),
    .host_err_o  (host_err),
    .host_dat_o  (host_rdat),
    .wb          (wb.master)
  );

  // stimulus timeline
  bit            drv_req[NCYC], drv_we[NCYC];
  logic [AW-1:0] drv_adr[NCYC];
  logic [3:0]    drv_sel[NCYC];
  logic [31:0]   drv_wdat[NCYC], drv_rdat[NCYC];
  bit            drv_ack[NCYC], drv_err[NCYC], drv_rty[NCYC], drv_stall[NCYC], resp_set[NCYC];
  // expected timeline
  bit            e_cyc[NCYC], e_stb[NCYC], e_rdy[NCYC], e_done[NCYC], e_err[NCYC], e_we[NCYC];
  logic [AW-1:0] e_adr[NCYC];
  logic [3:0]    e_sel[NCYC];
  logic [31:0]   e_wdat[NCYC], e_hdat[NCYC], hd_val[NCYC];
  bit            hd_upd[NCYC];
  logic [31:0]   mem[1<<AW];

  int p_kind[MR+1], p_s[MR+1], p_l[MR+1];
  int n_vec = 0, n_err = 0, cur = -1;
  int lit_b, lit_c, lit_e, lit_f, lit_g, lit_h;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cur, act, exp);
    end
  endtask

  // Lay one host transaction onto the timeline; slave replies are scripted relative to each
  // attempt's first strobe cycle c: stall for s cycles, reply l cycles after acceptance.
  task automatic sched(input int c_req, input bit we, input logic [AW-1:0] adr,
                       input logic [3:0] sel, input logic [31:0] d,
                       output int done_c, output int busy);
    int c, off, tend, r;
    bit timed, fin;
    drv_req[c_req] = 1'b1; drv_we[c_req] = we; drv_adr[c_req] = adr;
    drv_sel[c_req] = sel;  drv_wdat[c_req] = d;
    busy = c_req; c = c_req + 1; fin = 1'b0; done_c = c_req;
    for (int k = 0; k <= int'(MR) && !fin; k++) begin
      off   = (p_kind[k] == K_NONE) ? int'(TMO) + 1 : p_s[k] + p_l[k];
      timed = off > int'(TMO) - 1;
      tend  = timed ? c + int'(TMO) - 1 : c + off;
      for (int o = 0; o <= tend - c; o++) begin
        e_cyc[c+o] = 1'b1; e_stb[c+o] = (o <= p_s[k]); e_rdy[c+o] = 1'b0;
        e_we[c+o] = we; e_adr[c+o] = adr; e_sel[c+o] = sel; e_wdat[c+o] = d;
        if (o < p_s[k]) drv_stall[c+o] = 1'b1;
      end
      if (p_s[k] <= tend - c) drv_stall[c+p_s[k]] = 1'b0;
      r = c + off;
      resp_set[r] = 1'b1;
      drv_rdat[r] = mem[adr];
      drv_ack[r]  = (p_kind[k] == K_ACK || p_kind[k] == K_NONE) ? 1'b1 : 1'($urandom);
      drv_err[r]  = (p_kind[k] == K_ERR);
      drv_rty[r]  = (p_kind[k] == K_RTY) ? 1'b1 : 1'($urandom);
      if (p_kind[k] == K_RTY) drv_ack[r] = 1'b0;
      if (r > busy) busy = r;
      if (!timed && p_kind[k] == K_RTY && k < int'(MR)) begin
        e_rdy[tend+1] = 1'b0;
        c = tend + 2;
      end else begin
        fin = 1'b1;
        done_c = tend + 1;
        e_done[done_c] = 1'b1;
        e_err[done_c]  = timed || p_kind[k] != K_ACK;
        if (!timed && p_kind[k] == K_ACK) begin
          if (we) begin
            for (int b = 0; b < 4; b++) if (sel[b]) mem[adr][8*b +: 8] = d[8*b +: 8];
          end else begin
            hd_upd[done_c] = 1'b1;
            hd_val[done_c] = drv_rdat[r];
          end
        end
        if (done_c > busy) busy = done_c;
      end
    end
  endtask

  task automatic plan1(input int k, input int kind, input int s, input int l);
    p_kind[k] = kind; p_s[k] = s; p_l[k] = l;
  endtask

  task automatic build();
    int c, dc, busy;
    logic [31:0] cur_hd;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    for (int k = 0; k < NCYC; k++) begin
      drv_req[k] = 0; drv_we[k] = 1'($urandom); drv_adr[k] = AW'($urandom);
      drv_sel[k] = 4'($urandom); drv_wdat[k] = $urandom; drv_rdat[k] = $urandom;
      drv_ack[k] = 0; drv_err[k] = 0; drv_rty[k] = 0; drv_stall[k] = 1'($urandom);
      resp_set[k] = 0; e_cyc[k] = 0; e_stb[k] = 0; e_rdy[k] = 1; e_done[k] = 0; e_err[k] = 0;
      e_we[k] = 0; e_adr[k] = '0; e_sel[k] = '0; e_wdat[k] = '0; hd_upd[k] = 0; hd_val[k] = '0;
    end
    c = 1;
    plan1(0, K_ACK, 1, 0);
    sched(c, 1'b1, AW'(1), 4'hF, 32'hDEADBEEF, dc, busy); c = (dc > busy) ? dc : busy;
    lit_b = c; sched(c, 1'b0, AW'(1), 4'hF, 32'h0, dc, busy); c = (dc > busy) ? dc : busy;
    plan1(0, K_ACK, 5, 0);
    lit_c = c; sched(c, 1'b1, AW'(2), 4'hF, 32'h12345678, dc, busy); c = dc;
    plan1(0, K_ACK, 0, 1);
    sched(c, 1'b0, AW'(2), 4'hF, 32'h0, dc, busy); c = (dc > busy) ? dc : busy;
    plan1(0, K_ERR, 0, 1);
    lit_e = c; sched(c, 1'b0, AW'(3), 4'hF, 32'h0, dc, busy); c = (dc > busy) ? dc : busy;
    plan1(0, K_RTY, 0, 1); plan1(1, K_RTY, 0, 1); plan1(2, K_ACK, 0, 1);
    lit_f = c; sched(c, 1'b1, AW'(4), 4'h3, 32'hCAFE0001, dc, busy); c = (dc > busy) ? dc : busy;
    plan1(2, K_RTY, 0, 1);
    lit_g = c; sched(c, 1'b0, AW'(5), 4'hF, 32'h0, dc, busy); c = (dc > busy) ? dc : busy;
    plan1(0, K_NONE, 0, 0);
    lit_h = c; sched(c, 1'b0, AW'(6), 4'hF, 32'h0, dc, busy); c = (dc > busy) ? dc : busy;
    while (c < NCYC - 64) begin
      for (int k = 0; k <= int'(MR); k++) begin
        int r;
        r = int'($urandom % 20);
        p_kind[k] = (r < 11) ? K_ACK : (r < 13) ? K_ERR : (r < 18) ? K_RTY : K_NONE;
        p_s[k] = ($urandom % 4 == 0) ? int'($urandom % 7) : int'($urandom % 2);
        p_l[k] = int'($urandom % 3);
      end
      sched(c, 1'($urandom), AW'($urandom), 4'($urandom), $urandom, dc, busy);
      c = ((dc > busy) ? dc : busy) + (($urandom % 2 == 0) ? 0 : int'($urandom % 3));
    end
    // noise that the bridge must ignore: replies while cyc is low, requests while busy
    for (int k = 0; k < NCYC; k++) begin
      if (!e_cyc[k] && !resp_set[k]) begin
        drv_ack[k] = ($urandom % 8 == 0); drv_err[k] = ($urandom % 8 == 0);
        drv_rty[k] = ($urandom % 8 == 0);
      end
      if (!e_rdy[k]) drv_req[k] = 1'($urandom);
    end
    cur_hd = '0;
    for (int k = 0; k < NCYC; k++) begin
      if (hd_upd[k]) cur_hd = hd_val[k];
      e_hdat[k] = cur_hd;
    end
  endtask

  task automatic apply(input int k);
    host_req  = drv_req[k];  host_we  = drv_we[k];  host_adr = drv_adr[k];
    host_sel  = drv_sel[k];  host_wdat = drv_wdat[k];
    wb.wb_ack_i = drv_ack[k]; wb.wb_err_i = drv_err[k]; wb.wb_rty_i = drv_rty[k];
    wb.wb_stall_i = drv_stall[k]; wb.wb_dat_i = drv_rdat[k];
  endtask

  task automatic idle_inputs();
    host_req = 0; host_we = 0; host_adr = '0; host_sel = '0; host_wdat = '0;
    wb.wb_ack_i = 0; wb.wb_err_i = 0; wb.wb_rty_i = 0; wb.wb_stall_i = 0; wb.wb_dat_i = '0;
  endtask

  task automatic check(input int k);
    chk("cyc", 32'(wb.wb_cyc_o), 32'(e_cyc[k]));
    chk("stb", 32'(wb.wb_stb_o), 32'(e_stb[k]));
    chk("ready", 32'(host_ready), 32'(e_rdy[k]));
    chk("done", 32'(host_done), 32'(e_done[k]));
    chk("host_dat", host_rdat, e_hdat[k]);
    if (e_done[k]) chk("err", 32'(host_err), 32'(e_err[k]));
    if (e_cyc[k]) begin
      chk("we", 32'(wb.wb_we_o), 32'(e_we[k]));
      chk("adr", 32'(wb.wb_adr_o), 32'(e_adr[k]));
      chk("sel", 32'(wb.wb_sel_o), 32'(e_sel[k]));
      chk("wdat", wb.wb_dat_o, e_wdat[k]);
    end
    if (k == lit_b + 3) begin
      chk("lit_bank_done", 32'(host_done), 32'd1);
      chk("lit_bank_err", 32'(host_err), 32'd0);
      chk("lit_bank_dat", host_rdat, 32'hDEADBEEF);
    end
    if (k == lit_c + 7) chk("lit_stall_done", 32'(host_done), 32'd1);
    if (k == lit_e + 3) begin
      chk("lit_err_err", 32'(host_err), 32'd1);
      chk("lit_err_dat", host_rdat, 32'h12345678);
    end
    if (k == lit_f + 9) begin
      chk("lit_rty2_done", 32'(host_done), 32'd1);
      chk("lit_rty2_err", 32'(host_err), 32'd0);
    end
    if (k == lit_g + 9) chk("lit_rty3_err", 32'({host_done, host_err}), 32'd3);
    if (k == lit_h + 9) chk("lit_tmo_err", 32'({host_done, host_err}), 32'd3);
    if (k == lit_h + 11) chk("lit_late_ack", 32'(host_done), 32'd0);
  endtask

  initial begin
    build();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    cur = -1;
    chk("rst_ready", 32'(host_ready), 32'd1);
    chk("rst_cyc", 32'({wb.wb_cyc_o, wb.wb_stb_o, host_done, host_err}), 32'd0);
    chk("rst_dat", host_rdat, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk); #1;
      apply(k);
      @(negedge clk);
      cur = k;
      check(k);
    end
    // asynchronous reset while strobing
    @(posedge clk); #1;
    idle_inputs();
    wb.wb_stall_i = 1'b1;
    host_req = 1'b1; host_adr = AW'(7);
    @(posedge clk); #1;
    host_req = 1'b0;
    cur = NCYC;
    chk("pre_rst_stb", 32'(wb.wb_stb_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_cyc_stb", 32'({wb.wb_cyc_o, wb.wb_stb_o, host_done}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(host_ready), 32'd1);
    chk("post_rst_done", 32'(host_done), 32'd0);
    @(negedge clk);
    chk("post_rst_done2", 32'({host_done, wb.wb_cyc_o}), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
